event_trigger_sched: RTL and testbench

//   Shares one event-trigger resource between NREQ requesters and sequences every firing.

---
 rtl/event_trigger_sched.sv | 147 ++++++++++++++
 tb/tb_event_trigger_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_trigger_sched.sv
// event_trigger_sched: shares one event-trigger resource between NREQ requesters.
// A request won in IDLE fires a one-cycle trig tagged with the winner's index. After
// HOLD_CYCLES hold-off cycles a one-hot done pulse goes back to that winner.
// Build option: define EVT_SCHED_FIXED_PRIO_EN for fixed priority, where the lowest index
// wins. When the macro is undefined, a rotating round-robin pointer picks the winner.
module event_trigger_sched #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 1,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic            trig,
  output logic [IDW-1:0]  trig_id,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic [15:0]     fire_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT,
    S_DONE
  } state_t;

  // The WAIT state counts down from HOLD_CYCLES-1 to 0, so it lasts exactly HOLD_CYCLES cycles.
  localparam logic [3:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   trig_id_reg, trig_id_next;
  logic [3:0]       hold_cnt_reg, hold_cnt_next;
  logic [15:0]      fire_count_reg, fire_count_next;
  logic [IDW-1:0]   grant_idx;
  logic             done_state;

  // Return the index of the lowest set bit. Return 0 when no bit is set.
  function automatic logic [IDW-1:0] lowest_set(input logic [NREQ-1:0] v);
    lowest_set = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDW'(i);
    end
  endfunction

`ifdef EVT_SCHED_FIXED_PRIO_EN
  // Fixed priority: the lowest requesting index always wins.
  always_comb begin
    grant_idx = lowest_set(req);
  end
`else
  logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [NREQ-1:0] rr_mask;
  logic [NREQ-1:0] req_upper;

  // Round robin: prefer requests at or above the pointer. Otherwise wrap to the lowest one.
  always_comb begin
    rr_mask   = ~((NREQ'(1) << rr_ptr_reg) - NREQ'(1));
    req_upper = req & rr_mask;
    if (|req_upper) grant_idx = lowest_set(req_upper);
    else            grant_idx = lowest_set(req);
  end

  // Advance the pointer to the index just past the winner, and only when a grant is taken.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (state_reg == S_IDLE && (|req)) begin
      if (grant_idx == IDW'(NREQ - 1)) rr_ptr_next = '0;
      else                             rr_ptr_next = grant_idx + IDW'(1);
    end
  end

  // Hold the round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr_reg <= '0;
    else       rr_ptr_reg <= rr_ptr_next;
  end
`endif

  // FSM next state and state-decoded outputs. Requests are looked at only in IDLE.
  always_comb begin
    state_next      = state_reg;
    trig_id_next    = trig_id_reg;
    hold_cnt_next   = hold_cnt_reg;
    fire_count_next = fire_count_reg;
    trig            = 1'b0;
    busy            = 1'b0;
    done_state      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (|req) begin
          state_next   = S_FIRE;
          trig_id_next = grant_idx;
        end
      end
      S_FIRE: begin
        trig            = 1'b1;
        busy            = 1'b1;
        fire_count_next = fire_count_reg + 16'd1;
        if (HOLD_CYCLES > 0) begin
          state_next    = S_WAIT;
          hold_cnt_next = HOLD_LOAD;
        end else begin
          state_next = S_DONE;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (hold_cnt_reg == 4'd0) state_next = S_DONE;
        else                      hold_cnt_next = hold_cnt_reg - 4'd1;
      end
      S_DONE: begin
        busy       = 1'b1;
        done_state = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State and datapath registers. Reset abandons any firing in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      trig_id_reg    <= '0;
      hold_cnt_reg   <= 4'd0;
      fire_count_reg <= 16'd0;
    end else begin
      state_reg      <= state_next;
      trig_id_reg    <= trig_id_next;
      hold_cnt_reg   <= hold_cnt_next;
      fire_count_reg <= fire_count_next;
    end
  end

  // Send the one-hot done pulse to the granted requester.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_done
      assign done[gi] = done_state && (trig_id_reg == IDW'(gi));
    end
  endgenerate

  assign trig_id    = trig_id_reg;
  assign fire_count = fire_count_reg;

endmodule

// File: tb/tb_event_trigger_sched.sv
// tb_event_trigger_sched: two copies of event_trigger_sched share one request bus.
// Copy 0 uses HOLD_CYCLES=1 and copy 1 uses HOLD_CYCLES=0. A cycle-level reference model
// built from time offsets runs beside them, and per-scenario tasks check the headline
// behaviours.
module tb_event_trigger_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;

  logic       trig_a [2];
  logic [1:0] id_a   [2];
  logic [3:0] done_a [2];
  logic       busy_a [2];
  logic [15:0] fc_a  [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state per DUT: active flag, cycle offset since trig, winner, pointer, count.
  bit          m_active [2] = '{0, 0};
  int          m_off    [2] = '{0, 0};
  int          m_win    [2] = '{0, 0};
  int          m_ptr    [2] = '{0, 0};
  logic [15:0] m_count  [2] = '{16'd0, 16'd0};

  int ev_id[$];
  int ev_t[$];
  int dn_t[$];
  logic [3:0] dn_v[$];

  event_trigger_sched #(.NREQ(4), .HOLD_CYCLES(1)) u_dut_h1 (
    .clk(clk), .reset(rst), .req(req), .trig(trig_a[0]), .trig_id(id_a[0]),
    .done(done_a[0]), .busy(busy_a[0]), .fire_count(fc_a[0])
  );

  event_trigger_sched #(.NREQ(4), .HOLD_CYCLES(0)) u_dut_h0 (
    .clk(clk), .reset(rst), .req(req), .trig(trig_a[1]), .trig_id(id_a[1]),
    .done(done_a[1]), .busy(busy_a[1]), .fire_count(fc_a[1])
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int hold_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  // First requester at or after the search start (wrapping) wins.
  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return 0;
  endfunction

  // Compare every cycle against the model, then advance the model with the request that
  // the next rising edge will see.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic        e_trig, e_busy;
      logic [3:0]  e_done;
      logic [15:0] e_cnt;
      e_busy = !rst && m_active[d];
      e_trig = e_busy && (m_off[d] == 0);
      e_done = (e_busy && m_off[d] == hold_of(d) + 1) ? 4'(1 << m_win[d]) : 4'b0000;
      e_cnt  = rst ? 16'd0 : m_count[d];
      n_checks++;
      if ({trig_a[d], busy_a[d], done_a[d], fc_a[d]} !== {e_trig, e_busy, e_done, e_cnt}) begin
        n_fail++;
        $display("FAIL model_dut%0d t=%0t: trig/busy/done/count got %b/%b/%b/%h required %b/%b/%b/%h",
                 d, $time, trig_a[d], busy_a[d], done_a[d], fc_a[d], e_trig, e_busy, e_done, e_cnt);
      end
      if (e_busy) begin
        n_checks++;
        if (id_a[d] !== 2'(m_win[d])) begin
          n_fail++;
          $display("FAIL model_id_dut%0d t=%0t: trig_id got %0d required %0d", d, $time, id_a[d], m_win[d]);
        end
      end
      if (rst) begin
        m_active[d] = 0;
        m_count[d]  = 16'd0;
        m_ptr[d]    = 0;
        m_win[d]    = 0;
      end else if (m_active[d]) begin
        if (m_off[d] == 0) m_count[d] = m_count[d] + 16'd1;
        if (m_off[d] == hold_of(d) + 1) m_active[d] = 0;
        else                            m_off[d] = m_off[d] + 1;
      end else if (req != 4'b0000) begin
`ifdef EVT_SCHED_FIXED_PRIO_EN
        m_win[d] = pick(req, 0);
`else
        m_win[d] = pick(req, m_ptr[d]);
        m_ptr[d] = (m_win[d] + 1) % 4;
`endif
        m_active[d] = 1;
        m_off[d]    = 0;
      end
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    wait_cycle();
    rst = 1'b1;
    req = 4'b0000;
    wait_cycle();
    wait_cycle();
    rst = 1'b0;
  endtask

  // Hold req constant and log trig and done events of the selected DUT.
  task automatic collect(input int sel, input int ncyc);
    ev_id.delete(); ev_t.delete(); dn_t.delete(); dn_v.delete();
    for (int c = 0; c < ncyc; c++) begin
      wait_cycle();
      if (trig_a[sel]) begin ev_id.push_back(int'(id_a[sel])); ev_t.push_back(c); end
      if (done_a[sel] != 4'b0000) begin dn_t.push_back(c); dn_v.push_back(done_a[sel]); end
    end
  endtask

  task automatic test_reset();
    wait_cycle();
    rst = 1'b1;
    req = 4'b1111;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({trig_a[d], busy_a[d], done_a[d], fc_a[d], id_a[d]} !== 24'd0) begin
        n_fail++;
        $display("FAIL reset_assert dut%0d: trig/busy/done/count/id got %b/%b/%b/%h/%0d required all zero",
                 d, trig_a[d], busy_a[d], done_a[d], fc_a[d], id_a[d]);
      end
    end
    wait_cycle();
    wait_cycle();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({trig_a[d], busy_a[d], done_a[d], fc_a[d]} !== 22'd0) begin
        n_fail++;
        $display("FAIL reset_hold dut%0d: trig/busy/done/count got %b/%b/%b/%h required all zero",
                 d, trig_a[d], busy_a[d], done_a[d], fc_a[d]);
      end
    end
    req = 4'b0000;
    rst = 1'b0;
    wait_cycle();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (busy_a[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle dut%0d: busy got %b required 0", d, busy_a[d]);
      end
    end
  endtask

  task automatic test_single();
    int t, td, busy_n;
    logic [3:0] dv;
    logic [1:0] idv;
    t = -1; td = -1; busy_n = 0; dv = 4'b0000; idv = 2'd0;
    apply_reset();
    req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      wait_cycle();
      if (trig_a[0] && t < 0) begin t = c; idv = id_a[0]; end
      if (busy_a[0]) busy_n++;
      if (done_a[0] != 4'b0000 && td < 0) begin
        td = c; dv = done_a[0];
        req = req & ~done_a[0];
      end
    end
    n_checks++;
    if (t < 0) begin n_fail++; $display("FAIL single_trig: no trig within 10 cycles, required one"); end
    n_checks++;
    if (idv !== 2'd2) begin n_fail++; $display("FAIL single_id: trig_id got %0d required 2", idv); end
    n_checks++;
    if (td != t + 2) begin n_fail++; $display("FAIL single_done_time: done at cycle %0d required %0d", td, t + 2); end
    n_checks++;
    if (dv !== 4'b0100) begin n_fail++; $display("FAIL single_done_val: done got %b required 0100", dv); end
    n_checks++;
    if (busy_n != 3) begin n_fail++; $display("FAIL single_busy: busy cycles got %0d required 3", busy_n); end
    n_checks++;
    if (fc_a[0] !== 16'd1) begin n_fail++; $display("FAIL single_count: fire_count got %0d required 1", fc_a[0]); end
  endtask

  task automatic test_round_robin();
    int exp_ids[5];
`ifdef EVT_SCHED_FIXED_PRIO_EN
    exp_ids = '{0, 0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 2, 3, 0};
`endif
    apply_reset();
    req = 4'b1111;
    collect(0, 22);
    n_checks++;
    if (ev_id.size() < 5) begin
      n_fail++;
      $display("FAIL rr_count: trig pulses got %0d required at least 5", ev_id.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (ev_id[k] != exp_ids[k]) begin
          n_fail++;
          $display("FAIL rr_id[%0d]: trig_id got %0d required %0d", k, ev_id[k], exp_ids[k]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (ev_t[k + 1] - ev_t[k] != 4) begin
          n_fail++;
          $display("FAIL rr_period[%0d]: trig spacing got %0d required 4", k, ev_t[k + 1] - ev_t[k]);
        end
      end
    end
  endtask

  task automatic test_pair();
    int exp_ids[4];
`ifdef EVT_SCHED_FIXED_PRIO_EN
    exp_ids = '{0, 0, 0, 0};
`else
    exp_ids = '{0, 3, 0, 3};
`endif
    apply_reset();
    req = 4'b1001;
    collect(0, 16);
    n_checks++;
    if (ev_id.size() != 4) begin
      n_fail++;
      $display("FAIL pair_count: trig pulses got %0d required 4", ev_id.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (ev_id[k] != exp_ids[k]) begin
          n_fail++;
          $display("FAIL pair_id[%0d]: trig_id got %0d required %0d", k, ev_id[k], exp_ids[k]);
        end
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int t, stale_done, t2;
    logic [1:0] id2;
    t = -1; stale_done = 0; t2 = -1; id2 = 2'd0;
    apply_reset();
    req = 4'b0100;
    for (int c = 0; c < 8 && t < 0; c++) begin
      wait_cycle();
      if (trig_a[0]) t = c;
    end
    n_checks++;
    if (t < 0) begin n_fail++; $display("FAIL rw_trig: no trig within 8 cycles, required one"); end
    wait_cycle();
    n_checks++;
    if ({busy_a[0], trig_a[0], done_a[0]} !== 6'b100000) begin
      n_fail++;
      $display("FAIL rw_in_wait: busy/trig/done got %b/%b/%b required 1/0/0000", busy_a[0], trig_a[0], done_a[0]);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({trig_a[0], done_a[0], busy_a[0], fc_a[0]} !== 22'd0) begin
      n_fail++;
      $display("FAIL rw_async: trig/done/busy/count got %b/%b/%b/%h required all zero",
               trig_a[0], done_a[0], busy_a[0], fc_a[0]);
    end
    wait_cycle();
    wait_cycle();
    req = 4'b0010;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      wait_cycle();
      if (done_a[0][2]) stale_done++;
      if (trig_a[0] && t2 < 0) begin t2 = c; id2 = id_a[0]; end
      req = req & ~done_a[0];
    end
    n_checks++;
    if (stale_done != 0) begin n_fail++; $display("FAIL rw_no_done: abandoned done pulses got %0d required 0", stale_done); end
    n_checks++;
    if (t2 < 0 || id2 !== 2'd1) begin n_fail++; $display("FAIL rw_id: trig_id got %0d (trig at %0d) required 1", id2, t2); end
    n_checks++;
    if (fc_a[0] !== 16'd1) begin n_fail++; $display("FAIL rw_count: fire_count got %0d required 1", fc_a[0]); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req = 4'b0010;
    collect(1, 12);
    n_checks++;
    if (ev_t.size() < 2 || dn_t.size() < 1) begin
      n_fail++;
      $display("FAIL b2b_events: trig/done counts got %0d/%0d required >=2/>=1", ev_t.size(), dn_t.size());
    end else begin
      n_checks++;
      if (dn_t[0] != ev_t[0] + 1) begin
        n_fail++;
        $display("FAIL b2b_done_time: done at %0d required %0d", dn_t[0], ev_t[0] + 1);
      end
      n_checks++;
      if (dn_v[0] !== 4'b0010) begin n_fail++; $display("FAIL b2b_done_val: done got %b required 0010", dn_v[0]); end
      n_checks++;
      if (ev_t[1] - ev_t[0] != 3) begin
        n_fail++;
        $display("FAIL b2b_period: trig spacing got %0d required 3", ev_t[1] - ev_t[0]);
      end
      n_checks++;
      if (ev_id[0] != 1 || ev_id[1] != 1) begin
        n_fail++;
        $display("FAIL b2b_id: trig_id got %0d,%0d required 1,1", ev_id[0], ev_id[1]);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      wait_cycle();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ((trig_a[d] && done_a[d] != 4'b0000) || !$onehot0(done_a[d])) begin
          n_fail++;
          $display("FAIL rand_excl dut%0d t=%0t: trig=%b done=%b, required trig/done exclusive and done one-hot",
                   d, $time, trig_a[d], done_a[d]);
        end
      end
      req = 4'($urandom) & 4'($urandom);
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
    req = 4'b0000;
    wait_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pair();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    wait_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
